// File: rtl/tcdm_bank_responder.sv
// Single-port TCDM memory bank with byte-enabled stores, a fixed-latency response
// pipeline and saturating load/store counters.
module tcdm_bank_responder #(
    parameter int unsigned AddrWidth   = 10,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned MemLatency  = 1,
    parameter bit          WriteRespOn = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic [AddrWidth-1:0]   add_i,
    input  logic                   wen_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic                   stall_i,
    output logic                   gnt_o,
    output logic                   vld_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [15:0]            rd_cnt_o,
    output logic [15:0]            wr_cnt_o
);

    localparam int unsigned NumWords = 2 ** AddrWidth;
    localparam int unsigned NumBytes = DataWidth / 8;

    if (MemLatency < 1 || MemLatency > 8) begin : gen_bad_latency
        $error("tcdm_bank_responder: MemLatency must be within 1..8");
    end
    if (DataWidth % 8 != 0) begin : gen_bad_width
        $error("tcdm_bank_responder: DataWidth must be a multiple of 8");
    end

    logic [DataWidth-1:0]  mem_q [NumWords];
    logic [MemLatency-1:0] vld_q;
    logic [DataWidth-1:0]  data_q [MemLatency];
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;

    logic                  accept;
    logic                  push_vld;
    logic [DataWidth-1:0]  push_data;

    assign gnt_o  = req_i & ~stall_i;
    assign accept = gnt_o;

    // Memory is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (accept && wen_i) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (be_i[i]) begin
                    mem_q[add_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        push_vld  = accept & (~wen_i | WriteRespOn);
        push_data = '0;
        if (accept && !wen_i) begin
            push_data = mem_q[add_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < MemLatency; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= push_vld;
            data_q[0] <= push_data;
            for (int i = 1; i < MemLatency; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (accept && !wen_i && rd_cnt_q != 16'hFFFF) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (accept && wen_i && wr_cnt_q != 16'hFFFF) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign vld_o    = vld_q[MemLatency-1];
    assign rdata_o  = vld_o ? data_q[MemLatency-1] : '0;
    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Scoreboard bench: u_dut (latency 3, write responses on) and u_dut_nw (latency 1,
// write responses off) share data/address/stall inputs but have separate requests.
module tb_tcdm_bank_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, req_nw = 1'b0, wen = 1'b0, stall = 1'b0;
    logic [9:0]  add = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt, vld, gnt_nw, vld_nw;
    logic [31:0] rdata, rdata_nw;
    logic [15:0] rd_cnt, wr_cnt, rd_cnt_nw, wr_cnt_nw;

    tcdm_bank_responder #(
        .AddrWidth(10), .DataWidth(32), .MemLatency(LAT), .WriteRespOn(1'b1)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .stall_i(stall), .gnt_o(gnt), .vld_o(vld),
        .rdata_o(rdata), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
    );

    tcdm_bank_responder #(
        .AddrWidth(10), .DataWidth(32), .MemLatency(1), .WriteRespOn(1'b0)
    ) u_dut_nw (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_nw), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .stall_i(stall), .gnt_o(gnt_nw), .vld_o(vld_nw),
        .rdata_o(rdata_nw), .rd_cnt_o(rd_cnt_nw), .wr_cnt_o(wr_cnt_nw)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          nvec = 0;
    int          nfail = 0;
    int unsigned cyc = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    int          nw_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vld_nw || rdata_nw != 32'h0) nw_pulses++;
    end

    // Monitor: every response must match the head of the scoreboard in data and cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vld) begin
                nvec++;
                if (sb.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_vld: got vld=1 data=%h at cycle %0d, required no response",
                             rdata, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (rdata !== mon_e.data || cyc != mon_e.due) begin
                        nfail++;
                        $display("FAIL resp: got data=%h at cycle %0d, required %h at cycle %0d",
                                 rdata, cyc, mon_e.data, mon_e.due);
                    end
                end
            end else begin
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    mon_e = sb.pop_front();
                    nvec++;
                    nfail++;
                    $display("FAIL missing_resp: got vld=0 at cycle %0d, required data=%h at cycle %0d",
                             cyc, mon_e.data, mon_e.due);
                end
                if (rdata !== 32'h0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL idle_rdata: got %h with vld=0, required 0", rdata);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] exp);
        req = 1'b1; wen = 1'b0; add = a; stall = 1'b0; be = 4'h0;
        sb.push_back('{cyc + LAT, exp});
        exp_rd++;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic store(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; wen = 1'b1; add = a; wdata = d; be = b; stall = 1'b0;
        sb.push_back('{cyc + LAT, 32'h0});
        exp_wr++;
        @(posedge clk); #1;
        req = 1'b0; wen = 1'b0;
    endtask

    task automatic idle(input int n);
        req = 1'b0; req_nw = 1'b0; wen = 1'b0; stall = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 16) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        if (sb.size() != 0) begin
            nvec++;
            nfail++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        // Reset state and combinational grant while in reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", {31'h0, vld}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rd_cnt", {16'h0, rd_cnt}, 32'h0);
        check("rst_wr_cnt", {16'h0, wr_cnt}, 32'h0);
        req = 1'b1; wen = 1'b0; stall = 1'b0;
        #1 check("rst_gnt_req", {31'h0, gnt}, 32'h1);
        check("rst_gnt_nw", {31'h0, gnt_nw}, 32'h0);
        stall = 1'b1;
        #1 check("rst_gnt_stall", {31'h0, gnt}, 32'h0);
        req = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Full store, RAW load, partial store, load
        store(10'd5, 32'hDEADBEEF, 4'hF);
        load(10'd5, 32'hDEADBEEF);
        store(10'd5, 32'h11223344, 4'b0101);
        load(10'd5, 32'hDE22BE44);
        drain();

        // Preload then four back-to-back loads
        store(10'd0, 32'd10, 4'hF);
        store(10'd1, 32'd11, 4'hF);
        store(10'd2, 32'd12, 4'hF);
        store(10'd3, 32'd13, 4'hF);
        load(10'd0, 32'd10);
        load(10'd1, 32'd11);
        load(10'd2, 32'd12);
        load(10'd3, 32'd13);
        drain();
        check("rd_cnt_b2b", {16'h0, rd_cnt}, exp_rd);
        check("wr_cnt_b2b", {16'h0, wr_cnt}, exp_wr);

        // Load-then-store keeps old data; store-then-load sees new data
        load(10'd5, 32'hDE22BE44);
        store(10'd5, 32'hCAFEF00D, 4'hF);
        load(10'd5, 32'hCAFEF00D);
        drain();

        // Two stalled stores while two loads are in flight
        load(10'd1, 32'd11);
        load(10'd2, 32'd12);
        for (int i = 0; i < 2; i++) begin
            req = 1'b1; wen = 1'b1; add = 10'd0; wdata = 32'hFFFFFFFF; be = 4'hF; stall = 1'b1;
            #1 check("gnt_stall", {31'h0, gnt}, 32'h0);
            @(posedge clk); #1;
        end
        idle(1);
        check("rd_cnt_stall", {16'h0, rd_cnt}, exp_rd);
        check("wr_cnt_stall", {16'h0, wr_cnt}, exp_wr);
        load(10'd0, 32'd10);
        drain();

        // Reset with a load in flight discards it; memory survives
        store(10'd7, 32'h12345678, 4'hF);
        drain();
        load(10'd7, 32'h12345678);
        rst_n = 1'b0;
        sb.delete();
        exp_rd = 0;
        exp_wr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_rd_cnt", {16'h0, rd_cnt}, 32'h0);
        check("post_rst_wr_cnt", {16'h0, wr_cnt}, 32'h0);
        idle(6);
        load(10'd7, 32'h12345678);
        drain();
        check("post_rst_rd_cnt1", {16'h0, rd_cnt}, 32'h1);

        // No write responses on u_dut_nw; store counter saturates
        nw_pulses = 0;
        req_nw = 1'b1; wen = 1'b1; add = 10'd9; wdata = 32'hA5A5A5A5; be = 4'hF;
        @(posedge clk); #1;
        idle(3);
        check("nw_wr_cnt1", {16'h0, wr_cnt_nw}, 32'h1);
        check("nw_no_vld1", nw_pulses, 32'h0);
        req_nw = 1'b1; wen = 1'b1;
        repeat (65539) @(posedge clk);
        #1;
        idle(3);
        check("nw_wr_cnt_sat", {16'h0, wr_cnt_nw}, 32'h0000FFFF);
        check("nw_rd_cnt", {16'h0, rd_cnt_nw}, 32'h0);
        check("nw_no_vld", nw_pulses, 32'h0);
        check("dut_wr_cnt_idle", {16'h0, wr_cnt}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_responder.md
TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

Interface
REQ-001 Parameter AddrWidth, default 10, is the word-address width; the bank SHALL hold 2**AddrWidth words.
REQ-002 Parameter DataWidth, default 32, is the word width; it SHALL be a multiple of 8.
REQ-003 Parameter MemLatency, default 1, is the cycles from acceptance to response; legal range is 1..8, and elaboration SHALL fail outside it.
REQ-004 Parameter WriteRespOn, default 1; when 1 the bank SHALL also return a response for writes.
REQ-005 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 req_i  input  1  request from the interconnect.
REQ-008 add_i  input  AddrWidth  word address.
REQ-009 wen_i  input  1  1 = store, 0 = load.
REQ-010 wdata_i  input  DataWidth  write data.
REQ-011 be_i  input  DataWidth/8  byte enables for stores; ignored for loads.
REQ-012 stall_i  input  1  bank busy; blocks grant.
REQ-013 gnt_o  output  1  grant.
REQ-014 vld_o  output  1  response valid.
REQ-015 rdata_o  output  DataWidth  response data.
REQ-016 rd_cnt_o  output  16  accepted-load counter.
REQ-017 wr_cnt_o  output  16  accepted-store counter.

Function
REQ-018 gnt_o SHALL equal req_i & ~stall_i, combinationally, with no registered dependency.
REQ-019 A transaction SHALL be accepted in a cycle where req_i and gnt_o are both 1; at most one is accepted per cycle.
REQ-020 On an accepted store, at that clock edge, each byte i of word add_i with be_i[i]=1 SHALL take wdata_i byte i; other bytes are unchanged.
REQ-021 On an accepted load, the word at add_i SHALL be captured at the acceptance edge; it includes every store accepted in earlier cycles.
REQ-022 Each accepted load SHALL raise vld_o exactly MemLatency cycles after its acceptance cycle, for one cycle, with the captured word on rdata_o.
REQ-023 Each accepted store SHALL raise vld_o exactly MemLatency cycles after acceptance when WriteRespOn=1, with rdata_o = 0; when WriteRespOn=0 it SHALL produce no response.
REQ-024 The response pipeline SHALL be a MemLatency-deep shift of {valid, data}, advancing every cycle, and it SHALL never stall.
  - stall_i affects only new grants.
  - Back-to-back acceptances SHALL give back-to-back responses, in order.
REQ-025 rdata_o SHALL be 0 in any cycle where vld_o=0.
REQ-026 rd_cnt_o and wr_cnt_o SHALL each increment by 1 per accepted load or store respectively.
  - Each SHALL saturate at 16'hFFFF and not wrap.
REQ-027 A load following a store to the same address in the next cycle SHALL return the stored data (read-after-write).
REQ-028 Responses to the same address SHALL preserve acceptance order: store then load returns the new data; load then store returns the old data.
REQ-029 req_i=1 with stall_i=1 SHALL have no effect on memory, the counters or the pipeline.

Reset
REQ-030 While rst_ni=0: vld_o=0, rdata_o=0, rd_cnt_o=0, wr_cnt_o=0, all pipeline valids 0; gnt_o still follows REQ-018.
REQ-031 Memory contents SHALL NOT be reset, and they SHALL be retained across a reset.
REQ-032 Reset asserted with responses in flight SHALL discard them: no vld_o pulse appears after reset release for pre-reset acceptances.

Verification
REQ-033 MemLatency=1: store add=5, wdata=32'hDEADBEEF, be=4'hF, then load add=5 in the next cycle -> write response vld_o=1 with rdata_o=0 one cycle after the store, then vld_o=1 with rdata_o=32'hDEADBEEF one cycle after the load.
REQ-034 Partial store add=5, wdata=32'h11223344, be=4'b0101 over 32'hDEADBEEF, then load -> rdata_o=32'hDE22BE44.
REQ-035 MemLatency=3: four back-to-back loads of add 0..3, preloaded with 10..13 -> vld_o high for 4 consecutive cycles starting 3 cycles after the first acceptance, with data 10,11,12,13; rd_cnt_o=4.
REQ-036 stall_i=1 for 2 cycles with req_i=1 -> gnt_o=0, counters unchanged, and responses already in flight still emerge on schedule.
REQ-037 MemLatency=2: load accepted, then rst_ni pulsed low the next cycle -> no vld_o afterwards, counters 0, and previously stored data still readable.
REQ-038 WriteRespOn=0: a store -> no vld_o pulse and wr_cnt_o=1; after 65540 stores, wr_cnt_o=16'hFFFF.
